// File: rtl/spm_ctrl_pkg.sv
// Shared definitions for the SPM sequencer: register offsets, CTRL bit
// positions and the sequencer state encoding.
package spm_ctrl_pkg;

  localparam logic [4:0] OFF_X_REG = 5'h00;
  localparam logic [4:0] OFF_Y_REG = 5'h04;
  localparam logic [4:0] OFF_P_LO  = 5'h08;
  localparam logic [4:0] OFF_P_HI  = 5'h0C;
  localparam logic [4:0] OFF_CTRL  = 5'h10;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_DONE   = 1;
  localparam int unsigned CTRL_BUSY   = 2;
  localparam int unsigned CTRL_IRQ_EN = 3;
  localparam int unsigned CTRL_SIGNED = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/spm_ctrl_seq.sv
// Sequencer for the bit-serial multiplier: clears the SPM, streams Y LSB
// first for 2*WIDTH cycles and assembles the serial product.
module spm_ctrl_seq
  import spm_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   y_i,
  output logic               busy_o,
  output logic               commit_o,
  output logic [2*WIDTH-1:0] p_o,
  output logic               spm_clr_o,
  output logic               spm_en_o,
  output logic               spm_y_o,
  input  logic               spm_p_i
);

  localparam int CW = $clog2(2*WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(2*WIDTH-1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   y_sh_q, y_sh_d;
  logic               fill_q, fill_d;
  logic [2*WIDTH-1:0] p_sh_q, p_sh_d;

  // Sequencer state, counter and shift registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      y_sh_q  <= '0;
      fill_q  <= 1'b0;
      p_sh_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_sh_q  <= y_sh_d;
      fill_q  <= fill_d;
      p_sh_q  <= p_sh_d;
    end
  end

  // Next-state logic; a START in DONE is accepted like one in IDLE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    y_sh_d   = y_sh_q;
    fill_d   = fill_q;
    p_sh_d   = p_sh_q;
    commit_o = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = CLEAR;
          y_sh_d  = y_i;
          fill_d  = signed_i & y_i[WIDTH-1];
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: state_d = SHIFT;
      SHIFT: begin
        // Y drains towards bit 0 while the fill bit supplies the upper half
        y_sh_d = {fill_q, y_sh_q[WIDTH-1:1]};
        p_sh_d = {spm_p_i, p_sh_q[2*WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          commit_o = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Committed on the edge into DONE, so the final sampled bit is included
  assign p_o       = p_sh_d;
  assign busy_o    = (state_q == CLEAR) || (state_q == SHIFT);
  assign spm_clr_o = (state_q == CLEAR);
  assign spm_en_o  = (state_q == SHIFT);
  assign spm_y_o   = (state_q == SHIFT) & y_sh_q[0];

endmodule

// File: rtl/spm_ctrl.sv
// Wishbone register front-end for the SPM sequencer.
// Optional signed product support via SPM_CTRL_SIGNED_EN.
module spm_ctrl
  import spm_ctrl_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic [31:0]      wbs_dat_o,
  output logic             wbs_ack_o,
  output logic             irq,
  output logic             spm_clr,
  output logic             spm_en,
  output logic [WIDTH-1:0] spm_x,
  output logic             spm_y,
  input  logic             spm_p
);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

  logic               req_s, ack_q, wr_q;
  logic [4:0]         off_q;
  logic [31:0]        wdat_q, dat_q, rdata_s, ctrl_rd_s;
  logic [3:0]         sel_q;
  logic               wr_fire_s, wr_x_s, wr_y_s, wr_ctrl_s, start_s;
  logic [WIDTH-1:0]   x_q, y_q;
  logic [2*WIDTH-1:0] p_q, p_next_s;
  logic               done_q, irq_en_q, signed_s;
  logic               busy_s, commit_s;
  logic               unused_s;

  assign unused_s = ^wbs_adr_i[1:0];

  assign req_s = wbs_cyc_i & wbs_stb_i & ~ack_q &
                 (wbs_adr_i[31:5] == BASE_ADDR[31:5]);

  // Writes take effect in the ack cycle, from the request captured here
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ack_q  <= 1'b0;
      wr_q   <= 1'b0;
      off_q  <= 5'h00;
      wdat_q <= 32'h0;
      sel_q  <= 4'h0;
      dat_q  <= 32'h0;
    end else begin
      ack_q  <= req_s;
      wr_q   <= req_s & wbs_we_i;
      off_q  <= {wbs_adr_i[4:2], 2'b00};
      wdat_q <= wbs_dat_i;
      sel_q  <= wbs_sel_i;
      dat_q  <= (req_s & ~wbs_we_i) ? rdata_s : 32'h0;
    end
  end

  assign wr_fire_s = ack_q & wr_q;
  assign wr_x_s    = wr_fire_s & (off_q == OFF_X_REG) & ~busy_s;
  assign wr_y_s    = wr_fire_s & (off_q == OFF_Y_REG) & ~busy_s;
  assign wr_ctrl_s = wr_fire_s & (off_q == OFF_CTRL);
  assign start_s   = wr_ctrl_s & wdat_q[CTRL_START] & ~busy_s;

  // Register file
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      p_q      <= '0;
      done_q   <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      if (wr_x_s) x_q <= WIDTH'(merge_bytes(32'(x_q), wdat_q, sel_q));
      if (wr_y_s) y_q <= WIDTH'(merge_bytes(32'(y_q), wdat_q, sel_q));
      if (wr_ctrl_s) irq_en_q <= wdat_q[CTRL_IRQ_EN];
      if (commit_s) p_q <= p_next_s;
      // Setting DONE wins over a simultaneous W1C
      if (commit_s) begin
        done_q <= 1'b1;
      end else if (start_s || (wr_ctrl_s && wdat_q[CTRL_DONE])) begin
        done_q <= 1'b0;
      end
    end
  end

`ifdef SPM_CTRL_SIGNED_EN
  logic signed_q;

  // Signed-mode control bit
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      signed_q <= 1'b0;
    end else if (wr_ctrl_s) begin
      signed_q <= wdat_q[CTRL_SIGNED];
    end
  end

  assign signed_s = signed_q;
`else
  assign signed_s = 1'b0;
`endif

  // Read-data selection for the current request
  always_comb begin
    ctrl_rd_s              = 32'h0;
    ctrl_rd_s[CTRL_DONE]   = done_q;
    ctrl_rd_s[CTRL_BUSY]   = busy_s;
    ctrl_rd_s[CTRL_IRQ_EN] = irq_en_q;
    ctrl_rd_s[CTRL_SIGNED] = signed_s;
    case ({wbs_adr_i[4:2], 2'b00})
      OFF_X_REG: rdata_s = 32'(x_q);
      OFF_Y_REG: rdata_s = 32'(y_q);
      OFF_P_LO:  rdata_s = 32'(p_q[WIDTH-1:0]);
      OFF_P_HI:  rdata_s = 32'(p_q[2*WIDTH-1:WIDTH]);
      OFF_CTRL:  rdata_s = ctrl_rd_s;
      default:   rdata_s = 32'h0;
    endcase
  end

  spm_ctrl_seq #(.WIDTH(WIDTH)) u_seq (
    .clk_i     (wb_clk_i),
    .rst_ni    (wb_rst_n),
    .start_i   (start_s),
    .signed_i  (signed_s),
    .y_i       (y_q),
    .busy_o    (busy_s),
    .commit_o  (commit_s),
    .p_o       (p_next_s),
    .spm_clr_o (spm_clr),
    .spm_en_o  (spm_en),
    .spm_y_o   (spm_y),
    .spm_p_i   (spm_p)
  );

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq       = done_q & irq_en_q;
  assign spm_x     = x_q;

endmodule

// File: tb/tb_spm_ctrl.sv
// Directed bench for spm_ctrl with a behavioural bit-serial multiplier model.
module tb_spm_ctrl;

  localparam logic [31:0] A_X    = 32'h3000_0000;
  localparam logic [31:0] A_Y    = 32'h3000_0004;
  localparam logic [31:0] A_PLO  = 32'h3000_0008;
  localparam logic [31:0] A_PHI  = 32'h3000_000C;
  localparam logic [31:0] A_CTRL = 32'h3000_0010;

  logic        clk, rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w, dat_r;
  logic        ack, irq, spm_clr, spm_en, spm_y, spm_p;
  logic [31:0] spm_x;

  int n_checks = 0;
  int n_fail   = 0;

  spm_ctrl dut (
    .wb_clk_i  (clk),
    .wb_rst_n  (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_w),
    .wbs_dat_o (dat_r),
    .wbs_ack_o (ack),
    .irq       (irq),
    .spm_clr   (spm_clr),
    .spm_en    (spm_en),
    .spm_x     (spm_x),
    .spm_y     (spm_y),
    .spm_p     (spm_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SPM model: product bit k is final once partial products up to k are summed
  logic [63:0] m_acc, m_xext, m_sum;
  logic [5:0]  m_k;
  logic        m_signed;

  always_comb begin
    m_xext = m_signed ? {{32{spm_x[31]}}, spm_x} : {32'h0, spm_x};
    m_sum  = m_acc + (spm_y ? (m_xext << m_k) : 64'h0);
    spm_p  = spm_en ? m_sum[m_k] : 1'b0;
  end

  always @(posedge clk) begin
    if (spm_clr) begin
      m_acc <= 64'h0;
      m_k   <= 6'd0;
    end else if (spm_en) begin
      m_acc <= m_sum;
      m_k   <= m_k + 6'd1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output logic acked);
    acked = 1'b0;
    rd    = 32'h0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    for (int i = 0; i < 4 && !acked; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        acked = 1'b1;
        rd    = dat_r;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic acked;
    wb_xfer(a, 1'b1, d, 4'hF, rd, acked);
    check_eq($sformatf("wr_ack_%0h", a[7:0]), 64'(acked), 64'h1);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic acked;
    wb_xfer(a, 1'b0, 32'h0, 4'hF, rd, acked);
    check_eq({tag, "_ack"}, 64'(acked), 64'h1);
    check_eq(tag, 64'(rd), 64'(exp));
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (!spm_en && n < 300) begin @(posedge clk); #1; n++; end
    while (spm_en && n < 300) begin @(posedge clk); #1; n++; end
    check_eq("run_timeout", 64'(n < 300), 64'h1);
  endtask

  initial begin
    logic [31:0] rdv;
    logic        acked;
    int          cnt;

    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    sel = 4'h0; adr = 32'h0; dat_w = 32'h0; m_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_outputs", {57'h0, ack, irq, spm_clr, spm_en, spm_y, (spm_x != 32'h0), (dat_r != 32'h0)}, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    rd_chk("rst_ctrl", A_CTRL, 32'h0);
    rd_chk("rst_plo", A_PLO, 32'h0);

    // 3 * 5 with cycle-exact latency
    wr(A_X, 32'd3);
    wr(A_Y, 32'd5);
    wr(A_CTRL, 32'h1);
    @(posedge clk); #1;
    check_eq("clear_cycle", {62'h0, spm_clr, spm_en}, 64'h2);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (!spm_en) break;
      cnt++;
    end
    check_eq("shift_cycles", 64'(cnt), 64'd64);
    rd_chk("t1_ctrl", A_CTRL, 32'h2);
    check_eq("t1_irq", 64'(irq), 64'h0);
    rd_chk("t1_plo", A_PLO, 32'h0000_000F);
    rd_chk("t1_phi", A_PHI, 32'h0);

    // Max unsigned operands with interrupt
    wr(A_CTRL, 32'h8);
    wr(A_X, 32'hFFFF_FFFF);
    wr(A_Y, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h9);
    wait_run();
    rd_chk("t2_phi", A_PHI, 32'hFFFF_FFFE);
    rd_chk("t2_plo", A_PLO, 32'h0000_0001);
    check_eq("t2_irq", 64'(irq), 64'h1);
    wr(A_CTRL, 32'hA);
    check_eq("t2_irq_ack_cycle", 64'(irq), 64'h1);
    @(posedge clk); #1;
    check_eq("t2_irq_cleared", 64'(irq), 64'h0);

`ifdef SPM_CTRL_SIGNED_EN
    m_signed = 1'b1;
    wr(A_CTRL, 32'h10);
    wr(A_Y, 32'hFFFF_FFFE);
    wr(A_CTRL, 32'h11);
    wait_run();
    rd_chk("t3_plo", A_PLO, 32'h0000_0002);
    rd_chk("t3_phi", A_PHI, 32'h0);
    rd_chk("t3_ctrl", A_CTRL, 32'h12);
    m_signed = 1'b0;
`else
    wr(A_CTRL, 32'h10);
    rd_chk("t3_signed_ro", A_CTRL, 32'h0);
`endif

    // Writes and START while busy are acked but ignored
    wr(A_X, 32'd3);
    wr(A_Y, 32'd5);
    wr(A_CTRL, 32'h1);
    wr(A_X, 32'd7);
    wr(A_CTRL, 32'h1);
    rd_chk("t4_busy_ctrl", A_CTRL, 32'h4);
`ifdef SPM_CTRL_SIGNED_EN
    rd_chk("t4_prev_plo", A_PLO, 32'h0000_0002);
`else
    rd_chk("t4_prev_plo", A_PLO, 32'h0000_0001);
`endif
    wait_run();
    rd_chk("t4_x_kept", A_X, 32'd3);
    rd_chk("t4_plo", A_PLO, 32'h0000_000F);
    rd_chk("t4_ctrl", A_CTRL, 32'h2);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (spm_en || spm_clr) cnt++;
    end
    check_eq("t4_single_run", 64'(cnt), 64'd0);

    // Reset in the middle of SHIFT
    wr(A_CTRL, 32'h9);
    cnt = 0;
    while (!spm_en && cnt < 10) begin @(posedge clk); #1; cnt++; end
    repeat (20) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_outputs", {57'h0, ack, irq, spm_clr, spm_en, spm_y, (spm_x != 32'h0), (dat_r != 32'h0)}, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    rd_chk("t5_ctrl", A_CTRL, 32'h0);
    rd_chk("t5_plo", A_PLO, 32'h0);
    rd_chk("t5_x", A_X, 32'h0);
    wr(A_X, 32'd6);
    wr(A_Y, 32'd7);
    wr(A_CTRL, 32'h1);
    wait_run();
    rd_chk("t5_fresh_plo", A_PLO, 32'd42);
    rd_chk("t5_fresh_phi", A_PHI, 32'h0);

    // Byte-lane write and address decode
    wr(A_Y, 32'h1234_5678);
    wb_xfer(A_Y, 1'b1, 32'h0000_AB00, 4'b0010, rdv, acked);
    check_eq("t6_bytewr_ack", 64'(acked), 64'h1);
    rd_chk("t6_y_bytes", A_Y, 32'h1234_AB78);
    wb_xfer(32'h3000_0020, 1'b0, 32'h0, 4'hF, rdv, acked);
    check_eq("t6_oow_noack", 64'(acked), 64'h0);
    wb_xfer(32'h3000_0018, 1'b1, 32'hFFFF_FFFF, 4'hF, rdv, acked);
    check_eq("t6_hole_wr_ack", 64'(acked), 64'h1);
    rd_chk("t6_hole_rd", 32'h3000_0018, 32'h0);
    rd_chk("t6_y_after_hole", A_Y, 32'h1234_AB78);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
